// File: rtl/spike_servo_driver.sv
// spike_servo_driver
// Rate-decodes a LIF neuron spike train over a fixed window and turns the
// resulting spike count into a hobby-servo PWM pulse width. The width is only
// ever swapped in on a frame boundary, so the servo never sees a partial pulse.
module spike_servo_driver #(
  parameter int WIN_CYCLES   = 50000,
  parameter int FRAME_CYCLES = 1000000,
  parameter int PW_MIN       = 50000,
  parameter int PW_STEP      = 500,
  parameter int PW_MAX       = 100000,
  parameter int CNT_W        = 8,
  localparam int PW_W        = $clog2(FRAME_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike,
  input  logic             enable,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic [PW_W-1:0]  pulse_width,
  output logic             frame_start,
  output logic             pwm
);

  localparam int WIN_W  = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int PROD_W = CNT_W + $clog2(PW_STEP + 1);
  localparam int SUM_W  = ((PROD_W > PW_W) ? PROD_W : PW_W) + 1;

  // Window / rate decode state
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  spk_cnt_q, spk_cnt_d;
  logic [CNT_W-1:0]  rate_q, rate_d;
  logic              rate_valid_q, rate_valid_d;
  logic [CNT_W-1:0]  spk_sum;
  logic              win_last;

  // Rate-to-width mapping state
  logic [PW_W-1:0]   target_q, target_d;
  logic [PROD_W-1:0] pw_prod;
  logic [SUM_W-1:0]  pw_sum;

  // PWM frame state
  logic [PW_W-1:0]   fr_cnt_q, fr_cnt_d;
  logic [PW_W-1:0]   pulse_width_q, pulse_width_d;
  logic              armed_q, armed_d;
  logic              frame_start_q, frame_start_d;
  logic              pwm_q, pwm_d;
  logic              fr_last;

  assign win_last = (win_cnt_q == WIN_W'(WIN_CYCLES - 1));
  assign spk_sum  = (spike && (spk_cnt_q != {CNT_W{1'b1}})) ? spk_cnt_q + CNT_W'(1) : spk_cnt_q;

  // Window counter: accumulate saturating spike count, publish it on the last cycle
  always_comb begin
    win_cnt_d    = win_cnt_q;
    spk_cnt_d    = spk_cnt_q;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    if (!enable) begin
      win_cnt_d = '0;
      spk_cnt_d = '0;
    end else if (win_last) begin
      win_cnt_d    = '0;
      spk_cnt_d    = '0;
      rate_d       = spk_sum;
      rate_valid_d = 1'b1;
    end else begin
      win_cnt_d = win_cnt_q + WIN_W'(1);
      spk_cnt_d = spk_sum;
    end
  end

  // Linear map of the latest rate to a clamped pulse width, full-width before the clamp
  always_comb begin
    pw_prod  = PROD_W'(rate_q) * PROD_W'(PW_STEP);
    pw_sum   = SUM_W'(pw_prod) + SUM_W'(PW_MIN);
    target_d = target_q;
    if (rate_valid_q) begin
      if (pw_sum > SUM_W'(PW_MAX)) begin
        target_d = PW_W'(PW_MAX);
      end else begin
        target_d = pw_sum[PW_W-1:0];
      end
    end
  end

  assign fr_last = (fr_cnt_q == PW_W'(FRAME_CYCLES - 1));

  // Frame counter and PWM: width and enable are sampled only at the frame boundary
  always_comb begin
    fr_cnt_d      = fr_last ? '0 : fr_cnt_q + PW_W'(1);
    pulse_width_d = fr_last ? target_q : pulse_width_q;
    armed_d       = fr_last ? enable : (armed_q && enable);
    frame_start_d = fr_last;
    pwm_d         = armed_d && (fr_cnt_d < pulse_width_d);
  end

  // State registers, cleared immediately by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt_q     <= '0;
      spk_cnt_q     <= '0;
      rate_q        <= '0;
      rate_valid_q  <= 1'b0;
      target_q      <= PW_W'(PW_MIN);
      fr_cnt_q      <= '0;
      pulse_width_q <= PW_W'(PW_MIN);
      armed_q       <= 1'b0;
      frame_start_q <= 1'b0;
      pwm_q         <= 1'b0;
    end else begin
      win_cnt_q     <= win_cnt_d;
      spk_cnt_q     <= spk_cnt_d;
      rate_q        <= rate_d;
      rate_valid_q  <= rate_valid_d;
      target_q      <= target_d;
      fr_cnt_q      <= fr_cnt_d;
      pulse_width_q <= pulse_width_d;
      armed_q       <= armed_d;
      frame_start_q <= frame_start_d;
      pwm_q         <= pwm_d;
    end
  end

  assign rate        = rate_q;
  assign rate_valid  = rate_valid_q;
  assign pulse_width = pulse_width_q;
  assign frame_start = frame_start_q;
  assign pwm         = pwm_q;

endmodule

// File: tb/tb_spike_servo_driver.sv
// Testbench for spike_servo_driver with a small window/frame configuration.
// A window-pattern table feeds spikes; expected rates and per-frame widths go
// into queues that a negedge monitor drains as the DUT reports them.
module tb_spike_servo_driver;

  logic       clk;
  logic       reset;
  logic       spike;
  logic       enable;
  logic [3:0] rate;
  logic       rate_valid;
  logic [5:0] pulse_width;
  logic       frame_start;
  logic       pwm;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] mask;
    int          expRate;
    int          expPw;
  } winVec_t;

  winVec_t tbl[20];
  int      rateQ[$];
  int      pwQ[$];

  bit monOn     = 1'b0;
  int cyc       = 0;
  int lastRv    = -1;
  int lastFs    = -1;
  bit haveFrame = 1'b0;
  int curPw     = 0;
  int hiCnt     = 0;
  int stableErr = 0;
  int expR      = 0;
  int phase     = 0;

  spike_servo_driver #(
    .WIN_CYCLES  (16),
    .FRAME_CYCLES(64),
    .PW_MIN      (8),
    .PW_STEP     (2),
    .PW_MAX      (32),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spike      (spike),
    .enable     (enable),
    .rate       (rate),
    .rate_valid (rate_valid),
    .pulse_width(pulse_width),
    .frame_start(frame_start),
    .pwm        (pwm)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic noteFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got unexpected event, expected none", name);
  endtask

  // One clock cycle, sampled on the falling edge; phase tracks position in the frame
  task automatic stepCycle();
    @(negedge clk);
    if (frame_start) phase = 0;
    else phase++;
  endtask

  // Drive one 16-cycle window from a table entry and queue its expectations
  task automatic applyStimulus(input int w);
    rateQ.push_back(tbl[w].expRate);
    if ((w % 4) == 2) pwQ.push_back(tbl[w].expPw);
    for (int c = 0; c < 16; c++) begin
      spike = tbl[w].mask[c];
      stepCycle();
    end
  endtask

  // Scoreboard monitor: rate on every strobe, width/stability/period on every frame
  always @(negedge clk) begin
    if (monOn) begin
      cyc++;
      if (rate_valid) begin
        if (rateQ.size() == 0) begin
          noteFail("rateUnexpected");
        end else begin
          expR = rateQ.pop_front();
          checkOutput("rate", rate, expR);
        end
        if (lastRv >= 0) checkOutput("rateValidPeriod", cyc - lastRv, 16);
        lastRv = cyc;
      end
      if (frame_start) begin
        if (haveFrame) begin
          checkOutput("pwmWidth", hiCnt, curPw);
          checkOutput("pwStableMidFrame", stableErr, 0);
          checkOutput("frameStartPeriod", cyc - lastFs, 64);
        end
        if (pwQ.size() == 0) begin
          noteFail("framePwMissing");
          haveFrame = 1'b0;
        end else begin
          curPw = pwQ.pop_front();
          checkOutput("pwAtBoundary", pulse_width, curPw);
          haveFrame = 1'b1;
        end
        hiCnt     = pwm;
        stableErr = 0;
        lastFs    = cyc;
      end else if (haveFrame) begin
        hiCnt += pwm;
        if (pulse_width !== 6'(curPw)) stableErr++;
      end
    end
  end

  // Main sequence: reset, table-driven windows, then enable and async-reset corners
  initial begin
    int n;
    int hi;
    int rvSeen;
    bit sawStart;
    int firstRv;
    int firstFs;
    int rvRate;

    // mask bit c = spike on window cycle c; frame m takes its width from window 4m-2
    tbl[0]  = '{16'h0000, 0, 8};
    tbl[1]  = '{16'h0000, 0, 8};
    tbl[2]  = '{16'h0000, 0, 8};
    tbl[3]  = '{16'h0000, 0, 8};
    tbl[4]  = '{16'h0000, 0, 8};
    tbl[5]  = '{16'h0000, 0, 8};
    tbl[6]  = '{16'h0554, 5, 18};
    tbl[7]  = '{16'h8000, 1, 10};
    tbl[8]  = '{16'h0001, 1, 10};
    tbl[9]  = '{16'h0000, 0, 8};
    tbl[10] = '{16'hFFFF, 15, 32};
    tbl[11] = '{16'h0003, 2, 12};
    tbl[12] = '{16'h0000, 0, 8};
    tbl[13] = '{16'h0000, 0, 8};
    tbl[14] = '{16'h8001, 2, 12};
    tbl[15] = '{16'h0000, 0, 8};
    tbl[16] = '{16'h0000, 0, 8};
    tbl[17] = '{16'h0000, 0, 8};
    tbl[18] = '{16'h0000, 0, 8};
    tbl[19] = '{16'h0007, 3, 14};

    reset  = 1'b1;
    spike  = 1'b0;
    enable = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("resetRate", rate, 0);
    checkOutput("resetRateValid", rate_valid, 0);
    checkOutput("resetPulseWidth", pulse_width, 8);
    checkOutput("resetFrameStart", frame_start, 0);
    checkOutput("resetPwm", pwm, 0);

    repeat (2) @(negedge clk);
    enable = 1'b1;
    reset  = 1'b1;
    phase  = 0;
    monOn  = 1'b1;
    for (int w = 0; w < 20; w++) applyStimulus(w);
    spike = 1'b0;
    stepCycle();
    monOn = 1'b0;

    // Drop enable three cycles into the frame-5 pulse
    n = 0;
    while (phase != 3 && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput("dropWaitInBudget", n < 200, 1);
    checkOutput("pwmInPulseBeforeDrop", pwm, 1);
    enable = 1'b0;
    stepCycle();
    checkOutput("pwmDropNextEdge", pwm, 0);

    // Stay disabled into the next frame, up to its cycle 20
    n = 0; rvSeen = 0; hi = 0; sawStart = 1'b0;
    while (!(sawStart && phase == 20) && n < 300) begin
      stepCycle();
      n++;
      rvSeen += rate_valid;
      hi     += pwm;
      if (frame_start) sawStart = 1'b1;
    end
    checkOutput("disabledWaitInBudget", n < 300, 1);
    checkOutput("noRateValidWhileDisabled", rvSeen, 0);
    checkOutput("pwmLowWhileDisabled", hi, 0);
    checkOutput("rateHeldWhileDisabled", rate, 3);
    checkOutput("pwLoadedWhileDisabled", pulse_width, 14);

    // Re-enable mid-frame with a saturating spike train
    enable = 1'b1;
    spike  = 1'b1;
    n = 0; hi = 0;
    stepCycle();
    while (!frame_start && n < 100) begin
      hi += pwm;
      stepCycle();
      n++;
    end
    checkOutput("reenableWaitInBudget", n < 100, 1);
    checkOutput("noPartialPulse", hi, 0);
    checkOutput("pwSaturatedClamp", pulse_width, 32);
    hi = pwm;
    repeat (63) begin
      stepCycle();
      hi += pwm;
    end
    checkOutput("fullPulseAfterEnable", hi, 32);

    // Asynchronous reset between edges in the middle of a pulse
    n = 0;
    while (phase != 10 && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput("pwmBeforeReset", pwm, 1);
    #3 reset = 1'b0;
    #1;
    checkOutput("asyncResetPwm", pwm, 0);
    checkOutput("asyncResetPulseWidth", pulse_width, 8);
    checkOutput("asyncResetRate", rate, 0);
    spike = 1'b0;
    stepCycle();
    stepCycle();
    reset = 1'b1;
    phase = 0;

    // Behaviour after release matches a fresh start
    firstRv = -1; firstFs = -1; rvRate = -1;
    for (int k = 1; k <= 64; k++) begin
      stepCycle();
      if (rate_valid && firstRv < 0) begin
        firstRv = k;
        rvRate  = int'(rate);
      end
      if (frame_start && firstFs < 0) firstFs = k;
    end
    checkOutput("postResetFirstRateValid", firstRv, 16);
    checkOutput("postResetRate", rvRate, 0);
    checkOutput("postResetFirstFrameStart", firstFs, 64);
    hi = pwm;
    repeat (63) begin
      stepCycle();
      hi += pwm;
    end
    checkOutput("postResetPwmWidth", hi, 8);

    checkOutput("rateQueueDrained", rateQ.size(), 0);
    checkOutput("pwQueueDrained", pwQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_servo_driver.md
Name: spike_servo_driver

Overview:
- Downstream consumer of the LIF neuron `spike` output.
- Rate-decodes the spike train over a fixed window into a spike count.
- Maps that count linearly to a servo pulse width and drives a hobby-servo PWM frame for one robo-dog leg joint.
- Pulse width changes only at frame boundaries, so the servo never sees a truncated or stretched pulse.

Parameters:
- WIN_CYCLES, 50000: spike-count window length in clk cycles.
- FRAME_CYCLES, 1000000: PWM frame period in clk cycles (20 ms at 50 MHz).
- PW_MIN, 50000: pulse width in cycles at rate 0.
- PW_STEP, 500: added pulse cycles per counted spike.
- PW_MAX, 100000: pulse width clamp. Must satisfy PW_MIN <= PW_MAX < FRAME_CYCLES.
- CNT_W, 8: spike counter / rate width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- spike  in  1  spike from LIF neuron; every high cycle counts as one spike.
- enable  in  1  high = decode and drive; low = output idle.
- rate  out  CNT_W  spike count of the last completed window.
- rate_valid  out  1  one-cycle strobe when rate updates.
- pulse_width  out  PW_W  width currently applied, PW_W = clog2(FRAME_CYCLES).
- frame_start  out  1  one-cycle strobe on the first cycle of each PWM frame.
- pwm  out  1  servo drive.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately with no clock edge):
  - rate=0, rate_valid=0, frame_start=0, pwm=0, pulse_width=PW_MIN.
  - Internal spk_cnt=0, win_cnt=0, fr_cnt=0, target=PW_MIN.
  - Reset mid-pulse drops pwm at once.
- Window counter: win_cnt counts 0..WIN_CYCLES-1 and wraps.
  - On a non-final cycle: spk_cnt <= sat(spk_cnt + spike). Saturation is at 2^CNT_W-1; there is no wrap.
  - On the final cycle (win_cnt = WIN_CYCLES-1):
    - rate <= sat(spk_cnt + spike), so a spike on the last cycle belongs to the closing window.
    - spk_cnt <= 0.
    - rate_valid = 1 on the next cycle only.
  - A spike on the first cycle of a window counts in the new window.
- Target width is registered one cycle after rate updates:
  - target <= min(PW_MIN + rate*PW_STEP, PW_MAX).
  - The product is computed at full width, CNT_W + clog2(PW_STEP+1) bits, before the add and clamp; no truncation is allowed before the clamp.
- Frame counter: fr_cnt counts 0..FRAME_CYCLES-1 and wraps. It runs regardless of enable.
  - On the wrap cycle: pulse_width <= target.
  - A target arriving mid-frame is held until the next boundary.
  - If target changes twice within one frame, only the latest value is applied.
- Registered outputs:
  - frame_start <= (next fr_cnt == 0).
  - pwm <= enable && (next fr_cnt < next pulse_width).
  - Result: pwm rises in the same cycle frame_start is high and stays high for exactly pulse_width cycles.
- enable=0:
  - pwm forced 0 from the next edge.
  - win_cnt and spk_cnt held at 0; no rate_valid is issued.
  - rate, target and pulse_width hold their values.
- enable 0->1:
  - A fresh window starts at win_cnt=0.
  - If enable rises mid-frame, pwm resumes at the next frame boundary only. A partial pulse is forbidden, so a frame entered with enable=0 stays low all frame.
- Simultaneous window end and frame wrap: the frame loads the old target. The new rate reaches pulse_width at the following boundary.

Test Plan (sim params: WIN_CYCLES=16, FRAME_CYCLES=64, PW_MIN=8, PW_STEP=2, PW_MAX=32, CNT_W=4):
1. Reset applied, then released with enable=1, no spikes -> all outputs at reset values. Every frame: frame_start pulses every 64 cycles, pwm high exactly 8 cycles, rate_valid every 16 cycles with rate=0.
2. 5 isolated spikes in one window -> rate=5 with a one-cycle rate_valid. Target 18 is applied at the next frame wrap; the following frame has pwm high 18 cycles, and pulse_width does not change mid-frame.
3. spike held high for a full 16-cycle window -> rate=15 (saturated, no wrap). 8+30=38 clamps to pulse_width=32, pwm high 32 cycles.
4. Single spike only on the window's last cycle -> rate=1. Single spike only on the first cycle of the next window -> counted in that window, rate=1 again.
5. enable dropped 3 cycles into a pulse -> pwm low at the next edge, no rate_valid while low. enable raised at fr_cnt=20 -> pwm stays low until the next frame_start, then a full-width pulse.
6. reset asserted asynchronously mid-pulse (between clock edges) -> pwm=0 and pulse_width=8 immediately. After release, behaviour matches scenario 1.
